sram_mem_controller: RTL and testbench
======================================

Name: sram_mem_controller

Overview:
- Memory-side responder for the MEM stage.
- Accepts one 32-bit load/store per request and serialises it into two 16-bit accesses on an external SRAM.
- Returns load data to the MEM/WB path.
- Drives `ready`; the pipeline derives `freeze = ~ready` for every stage register, so the core stalls until the access completes.

Parameters:
- SRAM_WAIT, 2: cycles per 16-bit half-access; legal values are 1 or greater.
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- ADDR_W, 18: SRAM address width in half-words.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low (reset while `rst`==0)
- MEM_R_EN  in  1  load request, held level until `ready`
- MEM_W_EN  in  1  store request, held level until `ready`
- ALU_result  in  32  byte address
- ST_val  in  32  store data
- ready  out  1  access complete / no access pending
- Mem_read_value  out  32  load data
- sram_addr  out  ADDR_W  half-word address
- sram_dq_out  out  16  write data
- sram_dq_oe  out  1  data-bus drive enable
- sram_dq_in  in  16  read data
- sram_we_n  out  1  write strobe, active-low

Behaviour:
- Address mapping:
  - word = (ALU_result - BASE_ADDR) >> 2
  - low half = {word[ADDR_W-2:0], 0}; high half = {word[ADDR_W-2:0], 1}
  - Bits [1:0] are ignored.
- States and transitions:
  - IDLE: when a request is present, latch address, data and op, then go to LOW.
  - LOW: lasts SRAM_WAIT cycles, then go to HIGH.
  - HIGH: lasts SRAM_WAIT cycles, then go to DONE.
  - DONE: lasts 1 cycle, then go to IDLE.
- ready (combinational):
  - 0 in IDLE with a request present, and in LOW and HIGH.
  - 1 in DONE, and in IDLE with no request.
  - 1 while `rst`==0.
- Latency: `ready` is low for exactly 1 + 2*SRAM_WAIT cycles per access.
- DONE always returns to IDLE, so a held request is never re-issued. The next request is evaluated in IDLE.
- Store: during LOW and HIGH, `sram_dq_oe`=1, `sram_we_n`=0 and `sram_dq_out` = ST_val[15:0] or [31:16] respectively. Otherwise `sram_we_n`=1 and `sram_dq_oe`=0.
- Load: `sram_dq_in` is sampled on the last cycle of LOW into [15:0] and on the last cycle of HIGH into [31:16]. `Mem_read_value` is stable from DONE until the next load completes.
- Wait counter: 0..SRAM_WAIT-1, cleared on every phase entry.
- MEM_R_EN and MEM_W_EN both high: treated as a store.
- Request inputs changing after acceptance are ignored; the latched copies are used.
- Reset values:
  - state IDLE, counter 0, `Mem_read_value`=0
  - `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0
- Reset mid-access: the access is abandoned, no further strobes are issued, and the register values above apply on the next edge.

Optional Feature:
- Macro: SRAM_READ_BUFFER_EN
- Enabled:
  - One-entry buffer holding {valid, word, data}, filled at DONE of every load.
  - A load whose word matches a valid entry goes IDLE->DONE: `ready` is low 1 cycle, `Mem_read_value` = buffered data, no SRAM strobes.
  - A store to the buffered word invalidates the entry at acceptance.
  - Reset clears valid.
- Disabled: no buffer logic; every load takes full latency.

Decomposition:
- Shared package `mem_ctrl_pkg`:
  - state enum (IDLE, LOW, HIGH, DONE)
  - default constants SRAM_WAIT and BASE_ADDR
  - half-word select constants
- Natural sub-module: `sram_read_buffer`, instantiated only under SRAM_READ_BUFFER_EN. The rest is a single FSM with a counter.

Test Plan:
All scenarios use SRAM_WAIT=2 and a behavioural SRAM model.
- Idle, no requests, 10 cycles -> `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0 throughout.
- Store 0xDEADBEEF to 1028 -> half-word 2 written 0xBEEF then 3 written 0xDEAD; `ready` low exactly 5 cycles.
- Load from 1028 after the store -> `Mem_read_value`=0xDEADBEEF in DONE; `ready` low 5 cycles; `sram_we_n` stays 1.
- Back-to-back store(1024, 0x11112222) then load(1024), requests held until `ready` -> two distinct 5-cycle stalls, load returns 0x11112222, no duplicate write.
- MEM_R_EN and MEM_W_EN both 1, address 1032, ST_val 0xA5A5A5A5 -> store performed to half-words 4/5.
- `rst`=0 on the second LOW cycle of a store -> next edge: IDLE, `sram_we_n`=1, `sram_dq_oe`=0. With SRAM_READ_BUFFER_EN, a repeat load to 1028 -> `ready` low 1 cycle, 0xDEADBEEF.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the SRAM memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam int SRAM_WAIT_DEF = 2;
  localparam int BASE_ADDR_DEF = 1024;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_read_buffer.sv
// One-entry load buffer {valid, word, data}; used only with SRAM_READ_BUFFER_EN.
module sram_read_buffer
  import mem_ctrl_pkg::*;
#(
  parameter int WW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WW-1:0] lookup_word,
  input  logic          inv,
  input  logic          fill,
  input  logic [WW-1:0] fill_word,
  input  logic [31:0]   fill_data,
  output logic          hit,
  output logic [31:0]   hit_data
);

  logic          valid_q, valid_d;
  logic [WW-1:0] word_q, word_d;
  logic [31:0]   data_q, data_d;
  logic          match;

  assign match    = valid_q && (word_q == lookup_word);
  assign hit      = match;
  assign hit_data = data_q;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    data_d  = data_q;
    if (fill) begin
      valid_d = 1'b1;
      word_d  = fill_word;
      data_d  = fill_data;
    end else if (inv && match) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      word_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage responder: one 32-bit access as two 16-bit SRAM accesses.
// Optional one-entry load buffer under macro SRAM_READ_BUFFER_EN.
module sram_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int SRAM_WAIT = SRAM_WAIT_DEF,
  parameter int BASE_ADDR = BASE_ADDR_DEF,
  parameter int ADDR_W    = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       ST_val,
  output logic              ready,
  output logic [31:0]       Mem_read_value,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n
);

  localparam int CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam int WW = ADDR_W - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_WAIT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] word_q, word_d;
  logic [31:0]   st_q, st_d;
  logic          is_st_q, is_st_d;
  logic [15:0]   lo_q, lo_d;
  logic [31:0]   rd_q, rd_d;

  logic [31:0]   off;
  logic [WW-1:0] req_word;
  logic          req;
  logic          cnt_last;
  logic          hit;
  logic [31:0]   hit_data;
  logic          unused_off;

  assign off        = ALU_result - 32'(BASE_ADDR);
  assign req_word   = off[ADDR_W:2];
  assign unused_off = ^{off[31:ADDR_W+1], off[1:0]};
  assign req        = MEM_R_EN | MEM_W_EN;
  assign cnt_last   = (cnt_q == CNT_LAST);

`ifdef SRAM_READ_BUFFER_EN
  logic        buf_hit;
  logic [31:0] buf_data;

  sram_read_buffer #(
    .WW(WW)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .lookup_word(req_word),
    .inv        ((state_q == IDLE) && MEM_W_EN),
    .fill       ((state_q == DONE) && !is_st_q),
    .fill_word  (word_q),
    .fill_data  (rd_q),
    .hit        (buf_hit),
    .hit_data   (buf_data)
  );

  assign hit      = MEM_R_EN & ~MEM_W_EN & buf_hit;
  assign hit_data = buf_data;
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      st_q    <= '0;
      is_st_q <= 1'b0;
      lo_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      st_q    <= st_d;
      is_st_q <= is_st_d;
      lo_q    <= lo_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    st_d    = st_q;
    is_st_d = is_st_q;
    lo_d    = lo_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          word_d  = req_word;
          st_d    = ST_val;
          is_st_d = MEM_W_EN;
          state_d = hit ? DONE : LOW;
          if (hit) rd_d = hit_data;
        end
      end
      LOW: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = HIGH;
          if (!is_st_q) lo_d = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = DONE;
          // publish both halves at once so the result never tears
          if (!is_st_q) rd_d = {sram_dq_in, lo_q};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic busy;
  logic wr;

  always_comb begin
    busy  = (state_q == LOW) || (state_q == HIGH);
    wr    = busy && is_st_q;
    ready = !rst || (state_q == DONE) ||
            ((state_q == IDLE) && !req);
    sram_addr   = '0;
    sram_dq_out = '0;
    if (busy) begin
      sram_addr = {word_q,
                   (state_q == HIGH) ? HALF_HI : HALF_LO};
    end
    if (wr) begin
      sram_dq_out = (state_q == HIGH) ? st_q[31:16] : st_q[15:0];
    end
    sram_we_n      = !wr;
    sram_dq_oe     = wr;
    Mem_read_value = rd_q;
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Scoreboard bench for sram_mem_controller with a behavioural SRAM.
module tb_sram_mem_controller;

  localparam int W    = 2;
  localparam int BASE = 1024;
  localparam int FULL = 1 + 2 * W;

`ifdef SRAM_READ_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk = 0;
  logic        rst = 0;
  logic        r_en = 0;
  logic        w_en = 0;
  logic [31:0] addr = 0;
  logic [31:0] st_val = 0;
  logic        ready;
  logic [31:0] rd_val;
  logic [17:0] sram_addr;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [15:0] dq_in;
  logic        we_n;

  int checks = 0;
  int errors = 0;

  sram_mem_controller #(
    .SRAM_WAIT(W),
    .BASE_ADDR(BASE),
    .ADDR_W   (18)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .MEM_R_EN      (r_en),
    .MEM_W_EN      (w_en),
    .ALU_result    (addr),
    .ST_val        (st_val),
    .ready         (ready),
    .Mem_read_value(rd_val),
    .sram_addr     (sram_addr),
    .sram_dq_out   (dq_out),
    .sram_dq_oe    (dq_oe),
    .sram_dq_in    (dq_in),
    .sram_we_n     (we_n)
  );

  always #5 clk = ~clk;

  // behavioural SRAM, half-word addressed
  logic [15:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0;
  assign dq_in = mem[sram_addr[7:0]];
  always @(posedge clk) if (!we_n) mem[sram_addr[7:0]] <= dq_out;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // reference model: 32-bit words plus optional last-load buffer
  typedef struct {
    bit          ld;
    logic [31:0] data;
    int          lat;
    int          strobes;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [int];
  bit          b_valid = 0;
  int          b_word = 0;

  function automatic void model(input bit r, input bit w,
                                input logic [31:0] a,
                                input logic [31:0] d);
    exp_t e;
    int   wd;
    wd = int'((a - BASE) >> 2);
    if (w) begin
      ref_mem[wd] = d;
      if (b_valid && b_word == wd) b_valid = 0;
      e.ld = 0; e.data = 0; e.lat = FULL; e.strobes = 2 * W;
    end else begin
      e.ld   = 1;
      e.data = ref_mem.exists(wd) ? ref_mem[wd] : 32'h0;
      e.lat  = (BUF_EN && b_valid && b_word == wd) ? 1 : FULL;
      e.strobes = 0;
      b_valid = 1;
      b_word  = wd;
    end
    if (r || w) exp_q.push_back(e);
  endfunction

  // monitor: measure each ready-low run and compare at completion
  int low_cnt = 0;
  int wr_cnt  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      low_cnt = 0;
      wr_cnt  = 0;
    end else if (!ready) begin
      low_cnt++;
      if (!we_n) wr_cnt++;
    end else if (low_cnt > 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_access", 32'(low_cnt), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("stall_len", 32'(low_cnt), 32'(e.lat));
        check("strobes", 32'(wr_cnt), 32'(e.strobes));
        if (e.ld) check("load_data", rd_val, e.data);
      end
      low_cnt = 0;
      wr_cnt  = 0;
    end
  end

  // called at posedge+1; leaves request held, returns in the ready cycle
  task automatic do_req(input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit track);
    bit done = 0;
    r_en = r; w_en = w; addr = a; st_val = d;
    if (track) model(r, w, a, d);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready) begin done = 1; break; end
    end
    if (!done) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    r_en = 0; w_en = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_we_n", 32'(we_n), 32'd1);
    check("rst_oe", 32'(dq_oe), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_out", 32'(dq_out), 32'd0);
    check("rst_rdval", rd_val, 32'd0);
    rst = 1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_we_n", 32'(we_n), 32'd1);
      check("idle_oe", 32'(dq_oe), 32'd0);
    end

    do_req(0, 1, 1028, 32'hDEADBEEF, 1);
    idle(1);
    check("st_half2", 32'(mem[2]), 32'h0000BEEF);
    check("st_half3", 32'(mem[3]), 32'h0000DEAD);

    do_req(1, 0, 1028, 32'h0, 1);
    idle(2);

    do_req(0, 1, 1024, 32'h11112222, 1);
    do_req(1, 0, 1024, 32'h0, 1);
    idle(1);
    check("b2b_half0", 32'(mem[0]), 32'h00002222);
    check("b2b_half1", 32'(mem[1]), 32'h00001111);

    do_req(1, 1, 1032, 32'hA5A5A5A5, 1);
    idle(1);
    check("both_half4", 32'(mem[4]), 32'h0000A5A5);
    check("both_half5", 32'(mem[5]), 32'h0000A5A5);
    do_req(1, 0, 1032, 32'h0, 1);
    idle(1);

    // abandon a store on its second LOW cycle
    r_en = 0; w_en = 1; addr = 1028; st_val = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    w_en = 0;
    @(posedge clk); #1;
    check("abort_we_n", 32'(we_n), 32'd1);
    check("abort_oe", 32'(dq_oe), 32'd0);
    check("abort_addr", 32'(sram_addr), 32'd0);
    check("abort_rdval", rd_val, 32'd0);
    rst = 1;
    b_valid = 0;
    idle(2);
    check("abort_idle_ready", 32'(ready), 32'd1);

    do_req(1, 0, 1028, 32'h0, 1);
    do_req(1, 0, 1028, 32'h0, 1);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, d;
      int op;
      a  = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      d  = $urandom;
      op = $urandom_range(0, 3);
      case (op)
        0, 1: do_req(1, 0, a, d, 1);
        2:    do_req(0, 1, a, d, 1);
        default: do_req(1, 1, a, d, 1);
      endcase
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
